// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The response carries same-cycle data: imem_rdata is valid whenever imem_ready is high.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register of the 5-stage MIPS core: owns the PC, drives the
// imem handshake, applies hazard stalls and the decode-resolved branch/jump redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallF,
  input  logic                 stallD,
  input  logic                 pcsrcD,
  input  logic [31:0]          pc_branchD,
  input  logic                 jumpD,
  input  logic [31:0]          pc_jumpD,
  fetch_stage_if.master        imem,
  output logic [31:0]          instrD,
  output logic [31:0]          pcplus4D,
  output logic                 validD,
  output logic                 fetch_stall
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_BUF   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;

  logic        redir;
  logic [31:0] target;
  logic        deliver;
  logic [31:0] deliver_word;

  // A redirect held off by stallD is simply re-presented by decode next cycle.
  assign redir  = (pcsrcD | jumpD) & ~stallD;
  assign target = jumpD ? pc_jumpD : pc_branchD;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pc_d   = redir_pc_q;
    buf_d        = buf_q;
    deliver      = 1'b0;
    deliver_word = imem.imem_rdata;

    unique case (state_q)
      S_REQ: begin
        if (imem.imem_ready) begin
          if (redir) begin
            pc_d = target;
          end else if (!stallF) begin
            deliver = 1'b1;
            pc_d    = pc_q + 32'd4;
          end else begin
            buf_d   = imem.imem_rdata;
            state_d = S_BUF;
          end
        end else if (redir) begin
          // The outstanding request cannot be withdrawn; park the target until it drains.
          redir_pc_d = target;
          state_d    = S_DRAIN;
        end
      end

      S_BUF: begin
        deliver_word = buf_q;
        if (redir) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (!stallF) begin
          deliver = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end

      S_DRAIN: begin
        if (imem.imem_ready) begin
          pc_d    = redir ? target : redir_pc_q;
          state_d = S_REQ;
        end else if (redir) begin
          redir_pc_d = target;
        end
      end

      default: state_d = S_REQ;
    endcase
  end

  // IF/ID priority below reset: flush, then hold, then load word or bubble.
  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (redir) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!stallD) begin
      if (deliver) begin
        instr_d   = deliver_word;
        pcplus4_d = pc_q + 32'd4;
        valid_d   = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      redir_pc_q <= RESET_PC;
      // NOTE: buf_q is only read in S_BUF; it is cleared so reset state is fully deterministic.
      buf_q      <= '0;
      instr_q    <= NOP_INSTR;
      pcplus4_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
      buf_q      <= buf_d;
      instr_q    <= instr_d;
      pcplus4_q  <= pcplus4_d;
      valid_q    <= valid_d;
    end
  end

  assign imem.imem_req  = ~rst & (state_q != S_BUF);
  assign imem.imem_addr = pc_q;

  // Must depend only on state and imem_ready: the hazard unit feeds it back into stallF/stallD.
  assign fetch_stall = ((state_q == S_REQ) & ~imem.imem_ready) | (state_q == S_DRAIN);

  assign instrD   = instr_q;
  assign pcplus4D = pcplus4_q;
  assign validD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem returns the fetch address as the instruction word,
// so every expected instrD/pcplus4D below is derived directly from the address sequence.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stallF, stallD, pcsrcD, jumpD;
  logic [31:0] pc_branchD, pc_jumpD;
  logic [31:0] instrD, pcplus4D;
  logic        validD, fetch_stall;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_stage_if bus ();
  assign bus.imem_rdata = bus.imem_addr;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallF      (stallF),
    .stallD      (stallD),
    .pcsrcD      (pcsrcD),
    .pc_branchD  (pc_branchD),
    .jumpD       (jumpD),
    .pc_jumpD    (pc_jumpD),
    .imem        (bus.master),
    .instrD      (instrD),
    .pcplus4D    (pcplus4D),
    .validD      (validD),
    .fetch_stall (fetch_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are then changed and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_d(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                         input logic valid);
    check({tag, ".instrD"}, instrD, instr);
    check({tag, ".pcplus4D"}, pcplus4D, pc4);
    check({tag, ".validD"}, {31'd0, validD}, {31'd0, valid});
  endtask

  initial begin
    rst = 1'b1; stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0;
    pc_branchD = '0; pc_jumpD = '0; bus.imem_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst.req", {31'd0, bus.imem_req}, 32'd0);
    check_d("rst", 32'h0, 32'h0, 1'b0);
    check("rst.addr", bus.imem_addr, 32'h0);

    // 1. Zero-wait streaming
    rst = 1'b0;
    #1;
    check("s1.req", {31'd0, bus.imem_req}, 32'd1);
    check("s1.stall", {31'd0, fetch_stall}, 32'd0);
    tick();
    check_d("s1.w0", 32'h0, 32'h4, 1'b1);
    tick();
    check_d("s1.w4", 32'h4, 32'h8, 1'b1);
    check("s1.addr", bus.imem_addr, 32'h8);

    // 2. Three wait states on 0x8
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("s2.addr", bus.imem_addr, 32'h8);
      check("s2.stall", {31'd0, fetch_stall}, 32'd1);
      tick();
      check_d("s2.bubble", 32'h0, 32'h8, 1'b0);
    end
    bus.imem_ready = 1'b1;
    #1;
    check("s2.stall_off", {31'd0, fetch_stall}, 32'd0);
    tick();
    check_d("s2.w8", 32'h8, 32'hC, 1'b1);
    tick();
    check_d("s2.wC", 32'hC, 32'h10, 1'b1);
    check("s3.addr10", bus.imem_addr, 32'h10);

    // 3. Stall capture of 0x10 into the buffer
    stallF = 1'b1; stallD = 1'b1;
    tick();
    check("s3.req_buf", {31'd0, bus.imem_req}, 32'd0);
    check("s3.stall_buf", {31'd0, fetch_stall}, 32'd0);
    check_d("s3.hold1", 32'hC, 32'h10, 1'b1);
    tick();
    check("s3.req_buf2", {31'd0, bus.imem_req}, 32'd0);
    check_d("s3.hold2", 32'hC, 32'h10, 1'b1);
    stallF = 1'b0; stallD = 1'b0;
    tick();
    check_d("s3.w10", 32'h10, 32'h14, 1'b1);
    check("s3.addr14", bus.imem_addr, 32'h14);
    tick();
    check_d("s3.w14", 32'h14, 32'h18, 1'b1);
    tick();
    tick();
    tick();
    check_d("s3.w20", 32'h20, 32'h24, 1'b1);

    // 4. Branch while fetch of 0x24 waits
    bus.imem_ready = 1'b0; pcsrcD = 1'b1; pc_branchD = 32'h100;
    tick();
    pcsrcD = 1'b0; pc_branchD = 32'h0;
    check_d("s4.flush", 32'h0, 32'h24, 1'b0);
    check("s4.addr_drain", bus.imem_addr, 32'h24);
    check("s4.stall_drain", {31'd0, fetch_stall}, 32'd1);
    check("s4.req_drain", {31'd0, bus.imem_req}, 32'd1);
    tick();
    check("s4.addr_drain2", bus.imem_addr, 32'h24);
    bus.imem_ready = 1'b1;
    tick();
    check_d("s4.discard", 32'h0, 32'h24, 1'b0);
    check("s4.addr100", bus.imem_addr, 32'h100);
    tick();
    check_d("s4.w100", 32'h100, 32'h104, 1'b1);

    // 5. Jump beats branch; redirect ignored under stallD
    pcsrcD = 1'b1; jumpD = 1'b1; pc_jumpD = 32'h200; pc_branchD = 32'h300;
    stallF = 1'b1; stallD = 1'b1;
    tick();
    check_d("s5.hold", 32'h100, 32'h104, 1'b1);
    check("s5.addr_held", bus.imem_addr, 32'h104);
    stallF = 1'b0; stallD = 1'b0;
    tick();
    pcsrcD = 1'b0; jumpD = 1'b0;
    check("s5.addr200", bus.imem_addr, 32'h200);
    check_d("s5.flush", 32'h0, 32'h104, 1'b0);
    tick();
    check_d("s5.w200", 32'h200, 32'h204, 1'b1);

    // 6. PC wrap, then reset in the middle of a drain
    jumpD = 1'b1; pc_jumpD = 32'hFFFF_FFFC;
    tick();
    jumpD = 1'b0;
    check("s6.addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    check_d("s6.wrap", 32'hFFFF_FFFC, 32'h0, 1'b1);
    check("s6.addr_wrapped", bus.imem_addr, 32'h0);
    bus.imem_ready = 1'b0; pcsrcD = 1'b1; pc_branchD = 32'h40;
    tick();
    pc_branchD = 32'h80;
    check("s6.stall_drain", {31'd0, fetch_stall}, 32'd1);
    check("s6.addr_drain", bus.imem_addr, 32'h0);
    tick();
    pcsrcD = 1'b0; rst = 1'b1;
    #1;
    check("s6.req_in_rst", {31'd0, bus.imem_req}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("s6.addr_rst", bus.imem_addr, 32'h0);
    check_d("s6.rst", 32'h0, 32'h0, 1'b0);
    check("s6.stall_req", {31'd0, fetch_stall}, 32'd1);
    check("s6.req_after", {31'd0, bus.imem_req}, 32'd1);
    bus.imem_ready = 1'b1;
    tick();
    check_d("s6.w0", 32'h0, 32'h4, 1'b1);
    check("s6.addr4", bus.imem_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage and IF/ID pipeline register of the 5-stage MIPS core.
- Owns the PC and drives the instruction-memory request handshake.
- Applies stallF/stallD from the hazard unit and the branch/jump redirect resolved in decode.
- Reports memory wait states back as fetch_stall; the hazard unit ORs this into stallF/stallD/flushE.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID for bubbles and flushes.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stallF  in  1  hold PC/fetch (hazard unit)
- stallD  in  1  hold IF/ID register (hazard unit)
- pcsrcD  in  1  taken branch resolved in decode
- pc_branchD  in  32  branch target
- jumpD  in  1  jump in decode
- pc_jumpD  in  32  jump target
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address
- imem_ready  in  1  response valid this cycle (same-cycle data)
- imem_rdata  in  32  instruction word
- instrD  out  32  IF/ID instruction
- pcplus4D  out  32  IF/ID PC+4
- validD  out  1  IF/ID holds a real instruction
- fetch_stall  out  1  fetch cannot deliver this cycle

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous and active-high.
- Reset values: pcF=RESET_PC, state=REQ, buffer empty, instrD=NOP_INSTR, pcplus4D=0, validD=0. imem_req=0 during any cycle rst is high. The instruction memory shares rst, so no stale response survives reset.
- Redirect: redir = (pcsrcD|jumpD) & ~stallD. Target = jumpD ? pc_jumpD : pc_branchD (jump has priority).
- No delay slot. Redirect flushes IF/ID on that edge: instrD=NOP_INSTR, validD=0.
- IF/ID update priority: rst > redir (flush) > stallD (hold) > load.
  - Load is the delivered word when one is delivered, else a bubble (NOP_INSTR, validD=0, pcplus4D unchanged).
  - A word is delivered in REQ on imem_ready with ~stallF, or in BUF with ~stallF.
  - pcplus4D = fetched PC + 4, modulo 2^32 (wraps at 32'hFFFF_FFFC).
- Handshake: imem_addr must stay stable while imem_req=1 and imem_ready=0. A response cannot be cancelled; it must be consumed or discarded.
- State REQ (imem_req=1, imem_addr=pcF):
  - ready & redir: discard word; pcF<=target; stay REQ.
  - ready & ~redir & ~stallF: deliver word; pcF<=pcF+4; stay REQ.
  - ready & ~redir & stallF: capture word and PC into buffer; go BUF.
  - ~ready & redir: latch target into redir_pc; go DRAIN.
  - ~ready & ~redir: stay REQ (wait state).
- State BUF (imem_req=0):
  - redir: drop buffer; pcF<=target; go REQ.
  - ~stallF: deliver buffer; pcF<=pcF+4; go REQ.
  - else hold.
- State DRAIN (imem_req=1, imem_addr=old pcF):
  - ready: discard word; pcF<=redir_pc; go REQ.
  - Further redir in DRAIN overwrites redir_pc (latest wins).
- fetch_stall = (state==REQ & ~imem_ready) | (state==DRAIN). Combinational from state and imem_ready only; it must not depend on stallF/stallD, to avoid a loop.
- Simultaneous events:
  - stallF=1 with stallD=0: D still advances and receives a bubble.
  - stallD=1 with redirect inputs asserted: redirect ignored.
- rst asserted mid-REQ/DRAIN/BUF: state, PC and buffer return to reset values on that edge.

Test Plan:
1. Zero-wait streaming: imem_ready tied 1, word = address. After rst release, instrD shows 0,4,8,C on consecutive cycles; pcplus4D = instrD+4; validD=1 from the 2nd cycle after rst falls.
2. Wait states: imem_ready low 3 cycles for PC 0x8. imem_addr holds 0x8 and fetch_stall=1 for exactly 3 cycles; IF/ID receives 3 bubbles (validD=0); then 0x8 is delivered.
3. Stall capture: stallF=stallD=1 for 2 cycles on the ready cycle of 0x10. State BUF, imem_req=0. When stalls drop, instrD=word@0x10, next imem_addr=0x14, no word lost or duplicated.
4. Branch with wait: pcsrcD=1, pc_branchD=0x100 while the fetch of 0x24 is waiting. IF/ID flushed; the 0x24 response is discarded when ready arrives; the next imem_addr is 0x100; the first delivered word is from 0x100.
5. Jump priority and stallD: pcsrcD=jumpD=1, pc_jumpD=0x200, stallD=1 for 1 cycle. No redirect that cycle. When stallD drops, PC=0x200, not pc_branchD.
6. Wrap and reset: PC forced to 0xFFFF_FFFC, then rst mid-DRAIN. pcplus4D=0 before reset; after rst, imem_addr=RESET_PC, validD=0, state REQ.
